// File: rtl/linear_transfomation_cfg.sv
// Configuration controller for the 16-segment piecewise-linear transform.
// Host writes fill a shadow table; a validated commit swaps it into the active table at frame_start.
module linear_transfomation_cfg #(
    parameter int DSIZE = 12,
    parameter int DT_I  = 8,
    parameter int DT_D  = 4,
    localparam int DT   = DT_I + DT_D,
    localparam int DW   = (DSIZE > DT) ? DSIZE : DT
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [5:0]          wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                commit,
    input  logic                frame_start,
    output logic                busy,
    output logic                cfg_err,
    output logic                swap_done,
    output logic [16*DSIZE-1:0] m_flat,
    output logic [16*DSIZE-1:0] c_flat,
    output logic [16*DT-1:0]    d_flat
);

    typedef enum logic [1:0] {IDLE, CHECK, PEND} state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [DSIZE-1:0] m_sh [16];
    logic [DSIZE-1:0] c_sh [16];
    logic [DT-1:0]    d_sh [16];
    logic             wr_fire;

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign wr_fire  = wr_valid & wr_ready;

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cfg_err   <= 1'b0;
            swap_done <= 1'b0;
            m_flat    <= '0;
            c_flat    <= '0;
            d_flat    <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                m_sh[i] <= '0;
                c_sh[i] <= '0;
                d_sh[i] <= '0;
            end
        end else begin
            swap_done <= 1'b0;

            // Writes land on the same edge a concurrent commit enters CHECK, so the check sees them.
            if (wr_fire) begin
                case (wr_addr[5:4])
                    2'd0:    m_sh[wr_addr[3:0]] <= wr_data[DSIZE-1:0];
                    2'd1:    c_sh[wr_addr[3:0]] <= wr_data[DSIZE-1:0];
                    2'd2:    d_sh[wr_addr[3:0]] <= wr_data[DT-1:0];
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (commit) begin
                        idx     <= '0;
                        cfg_err <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (m_sh[idx] > m_sh[idx + 4'd1]) begin
                        cfg_err <= 1'b1;
                        state   <= IDLE;
                    end else if (idx == 4'd14) begin
                        state <= PEND;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                PEND: begin
                    if (frame_start) begin
                        for (int unsigned i = 0; i < 16; i++) begin
                            m_flat[i*DSIZE +: DSIZE] <= m_sh[i];
                            c_flat[i*DSIZE +: DSIZE] <= c_sh[i];
                            d_flat[i*DT +: DT]       <= d_sh[i];
                        end
                        swap_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
